// File: rtl/ds1302_xfer.sv
// DS1302 3-wire transfer engine: single/burst reads and writes on a self-generated SCLK,
// returning an atomically updated read image.
module ds1302_xfer #(
    parameter int unsigned CLK_DIV   = 100,
    parameter int unsigned NUM_BYTES = 7,
    parameter int unsigned CE_GUARD  = 400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             cmd_byte,
    input  logic [8*NUM_BYTES-1:0] wr_data,
    output logic [8*NUM_BYTES-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   sclk,
    output logic                   ce,
    inout  wire                    ds_io
);

    localparam int unsigned DW   = 8 * NUM_BYTES;
    localparam int unsigned TW   = DW + 8;
    localparam int unsigned PMAX = (CLK_DIV > CE_GUARD) ? CLK_DIV : CE_GUARD;
    localparam int unsigned CW   = $clog2(PMAX);
    localparam int unsigned BW   = $clog2(TW + 1);

    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST  = CW'(CE_GUARD - 1);
    localparam logic [BW-1:0] CMD_LAST    = BW'(7);
    localparam logic [BW-1:0] SINGLE_LAST = BW'(15);
    localparam logic [BW-1:0] BURST_LAST  = BW'(TW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CE_SETUP,
        ST_CMD,
        ST_DATA,
        ST_CE_HOLD,
        ST_RECOVER
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic          ce_q, ce_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          oe_q, oe_d;
    logic          rd_mode_q, rd_mode_d;
    logic          burst_q, burst_d;
    logic [TW-1:0] tx_q, tx_d;
    logic [DW-1:0] rx_q, rx_d;
    logic [DW-1:0] rd_q, rd_d;

    logic div_last_c;
    logic guard_last_c;
    logic bit_last_c;

    assign div_last_c   = (cnt_q == DIV_LAST);
    assign guard_last_c = (cnt_q == GUARD_LAST);
    assign bit_last_c   = (bit_q == (burst_q ? BURST_LAST : SINGLE_LAST));

    // Serial data is always the LSB of the transmit shift register.
    assign ds_io   = oe_q ? tx_q[0] : 1'bz;
    assign sclk    = sclk_q;
    assign ce      = ce_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oe_q      <= 1'b0;
            rd_mode_q <= 1'b0;
            burst_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            oe_q      <= oe_d;
            rd_mode_q <= rd_mode_d;
            burst_q   <= burst_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sclk_d    = sclk_q;
        ce_d      = ce_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        oe_d      = oe_q;
        rd_mode_d = rd_mode_q;
        burst_d   = burst_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_d      = rd_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CE_SETUP;
                    cnt_d     = '0;
                    bit_d     = '0;
                    ce_d      = 1'b1;
                    busy_d    = 1'b1;
                    tx_d      = {wr_data, cmd_byte};
                    rx_d      = '0;
                    rd_mode_d = cmd_byte[0];
                    burst_d   = (cmd_byte[5:1] == 5'h1F);
                end
            end
            ST_CE_SETUP: begin
                if (guard_last_c) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CMD, ST_DATA: begin
                if (!div_last_c) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!sclk_q) begin
                    // End of low phase: raise SCLK and capture read data.
                    cnt_d  = '0;
                    sclk_d = 1'b1;
                    if ((state_q == ST_DATA) && rd_mode_q) begin
                        rx_d = {ds_io, rx_q[DW-1:1]};
                    end
                end else begin
                    // End of high phase: next bit goes out with the falling edge.
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    tx_d   = tx_q >> 1;
                    bit_d  = bit_q + BW'(1);
                    if ((state_q == ST_CMD) && (bit_q == CMD_LAST)) begin
                        state_d = ST_DATA;
                        if (rd_mode_q) begin
                            oe_d = 1'b0;
                        end
                    end else if ((state_q == ST_DATA) && bit_last_c) begin
                        state_d = ST_CE_HOLD;
                        oe_d    = 1'b0;
                    end
                end
            end
            ST_CE_HOLD: begin
                if (guard_last_c) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                    ce_d    = 1'b0;
                    done_d  = 1'b1;
                    if (rd_mode_q) begin
                        // A single-byte read lands in the top byte of the shadow.
                        rd_d = burst_q ? rx_q : DW'(rx_q[DW-1 -: 8]);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RECOVER: begin
                if (guard_last_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ds1302_xfer.sv
// Randomized bench for ds1302_xfer against a behavioural DS1302 device and
// timing formulas derived from the transfer rules.
module tb_ds1302_xfer;

    localparam int unsigned CD = 4;
    localparam int unsigned CG = 8;
    localparam int unsigned NB = 7;
    localparam int unsigned DW = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    cmd_byte;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          sclk;
    logic          ce;
    wire           ds_io;

    ds1302_xfer #(.CLK_DIV(CD), .NUM_BYTES(NB), .CE_GUARD(CG)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd_byte (cmd_byte),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .sclk     (sclk),
        .ce       (ce),
        .ds_io    (ds_io)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tot_rises = 0;
    int viol = 0;
    logic ce_p = 1'b0;
    logic sclk_p = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sclk) tot_rises <= tot_rises + 1;

    // Protocol monitor: ce frozen around SCLK high, SCLK idle whenever ce is low.
    always @(negedge clk) begin
        if (rst) begin
            viol <= viol + int'(!ce && sclk) + int'((ce != ce_p) && (sclk || sclk_p));
        end
        ce_p   <= ce;
        sclk_p <= sclk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Device memory: owned by the main sequence, read by the device model.
    logic [7:0]  mem [32];
    logic        mdl_oe = 1'b0;
    logic        mdl_bit = 1'b0;
    logic [7:0]  lst_cmd = '0;
    logic [63:0] lst_w = '0;

    assign ds_io = mdl_oe ? mdl_bit : 1'bz;

    // DS1302 device model: command LSB-first on rises, read bits presented after falls.
    initial begin
        int          rises;
        int          wcnt;
        int          nb;
        logic [7:0]  m_cmd;
        logic [63:0] rbits;
        logic [63:0] wbits;
        logic        sclk_m;
        rises = 0; wcnt = 0; nb = 1; m_cmd = '0; rbits = '0; wbits = '0; sclk_m = 1'b0;
        forever begin
            @(sclk or ce);
            if (!ce) begin
                if (rises > 0) begin
                    lst_cmd = m_cmd;
                    lst_w   = (wcnt > 0) ? (wbits >> (64 - wcnt)) : 64'd0;
                end
                rises = 0; wcnt = 0; wbits = '0; mdl_oe = 1'b0;
            end else if (sclk && !sclk_m) begin
                if (rises < 8) begin
                    m_cmd = {ds_io, m_cmd[7:1]};
                end else if (!m_cmd[0]) begin
                    wbits = {ds_io, wbits[63:1]};
                    wcnt++;
                end
                rises++;
                if (rises == 8) begin
                    nb = (m_cmd[5:1] == 5'h1F) ? NB : 1;
                    rbits = '0;
                    if (nb == NB) begin
                        for (int k = NB - 1; k >= 0; k--) rbits = (rbits << 8) | 64'(mem[k]);
                    end else begin
                        rbits = 64'(mem[m_cmd[5:1]]);
                    end
                end
            end else if (!sclk && sclk_m) begin
                if (m_cmd[0] && rises >= 8 && rises < 8 + 8 * nb) begin
                    mdl_oe  = 1'b1;
                    mdl_bit = rbits[0];
                    rbits   = rbits >> 1;
                end else begin
                    mdl_oe = 1'b0;
                end
            end
            sclk_m = sclk;
        end
    end

    // Runs one transfer starting at the current negedge; returns at the negedge busy is low.
    task automatic run_xfer(input logic [7:0] c, input logic [DW-1:0] wd, input bit collide,
                            input string tag);
        int            nb, t_exp, e0, r0, done_cyc, dones, held, guard;
        logic [DW-1:0] rd_before, rd_exp, tmp;
        logic [63:0]   w_exp;
        bit            burst;
        burst     = (c[5:1] == 5'h1F);
        nb        = burst ? NB : 1;
        t_exp     = 2 * CG + 16 * CD * (nb + 1);
        rd_before = rd_data;
        if (!c[0]) begin
            rd_exp = rd_before;
        end else if (burst) begin
            rd_exp = '0;
            for (int k = NB - 1; k >= 0; k--) rd_exp = (rd_exp << 8) | DW'(mem[k]);
        end else begin
            rd_exp = DW'(mem[c[5:1]]);
        end
        w_exp = burst ? 64'(wd) : 64'(wd[7:0]);

        start = 1'b1; cmd_byte = c; wr_data = wd;
        e0 = cyc + 1; r0 = tot_rises;
        @(negedge clk);
        start = 1'b0; cmd_byte = 8'($urandom); wr_data = DW'({$urandom, $urandom});
        chk({tag, "_ce_on"}, 64'(ce), 64'd1);
        chk({tag, "_busy_on"}, 64'(busy), 64'd1);

        dones = 0; done_cyc = -1; held = 0; guard = 0;
        while (busy && guard < t_exp + int'(CG) + 100) begin
            start = collide && ((cyc == e0 + 4) || (dones > 0 && cyc == done_cyc + 3));
            @(negedge clk);
            guard++;
            if (done) begin
                dones++;
                done_cyc = cyc;
            end else if (dones == 0 && rd_data !== rd_before) begin
                held++;
            end
        end
        start = 1'b0;

        chk({tag, "_dones"}, 64'(dones), 64'd1);
        chk({tag, "_done_t"}, 64'(done_cyc - e0), 64'(t_exp));
        chk({tag, "_busy_t"}, 64'(cyc - e0), 64'(t_exp + int'(CG)));
        chk({tag, "_rises"}, 64'(tot_rises - r0), 64'(8 * (nb + 1)));
        chk({tag, "_held"}, 64'(held), 64'd0);
        chk({tag, "_rd"}, 64'(rd_data), 64'(rd_exp));
        chk({tag, "_cmd"}, 64'(lst_cmd), 64'(c));
        chk({tag, "_proto"}, 64'(viol), 64'd0);
        if (!c[0]) begin
            chk({tag, "_wdata"}, lst_w, w_exp);
            tmp = wd;
            for (int k = 0; k < nb; k++) begin
                mem[burst ? k : int'(c[5:1])] = tmp[7:0];
                tmp = tmp >> 8;
            end
        end
    endtask

    initial begin
        int          r0, guard, dn, op;
        logic [4:0]  addr;
        logic [7:0]  c;
        logic [55:0] img;
        rst = 1'b1; start = 1'b0; cmd_byte = '0; wr_data = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ce", 64'(ce), 64'd0);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        mem[0] = 8'h45;
        run_xfer(8'h81, '0, 1'b0, "rd1");

        img = 56'h24030815235930;
        for (int k = 0; k < 7; k++) begin
            mem[k] = img[7:0];
            img = img >> 8;
        end
        run_xfer(8'hBF, '0, 1'b0, "brd");
        run_xfer(8'h8E, '0, 1'b0, "wr1");
        run_xfer(8'h81, DW'($urandom), 1'b1, "coll");
        run_xfer(8'h83, '0, 1'b0, "b2b");

        // Reset in the middle of a burst read's data phase.
        r0 = tot_rises;
        start = 1'b1; cmd_byte = 8'hBF;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while ((tot_rises - r0) < 20 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("rstm_bit", 64'(tot_rises - r0), 64'd20);
        rst = 1'b0;
        #1;
        chk("rstm_ce", 64'(ce), 64'd0);
        chk("rstm_sclk", 64'(sclk), 64'd0);
        chk("rstm_busy", 64'(busy), 64'd0);
        chk("rstm_rd", 64'(rd_data), 64'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += int'(done);
        end
        rst = 1'b1;
        repeat (2 * CG) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("rstm_nodone", 64'(dn), 64'd0);
        chk("rstm_idle", 64'(busy), 64'd0);
        run_xfer(8'h81, '0, 1'b0, "post_rst");

        for (int it = 0; it < 16; it++) begin
            op   = int'($urandom_range(0, 3));
            addr = 5'($urandom_range(0, 30));
            case (op)
                0:       c = {2'b10, addr, 1'b1};
                1:       c = {2'b10, addr, 1'b0};
                2:       c = {2'b10, 5'h1F, 1'b1};
                default: c = {2'b10, 5'h1F, 1'b0};
            endcase
            run_xfer(c, DW'({$urandom, $urandom}), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
